// File: rtl/uart_avalon_pkg.sv
// Shared definitions for the Avalon-MM UART receiver: register offsets,
// register bit positions and the receive state machine encoding.
package uart_avalon_pkg;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam int RVALID_BIT = 15;
  localparam int RE_BIT     = 0;
  localparam int RI_BIT     = 8;
  localparam int FE_BIT     = 9;
  localparam int OE_BIT     = 10;
  localparam int AVAIL_LSB  = 16;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 serial receiver: input synchronizer, start/data/stop FSM and shift
// register. Emits one-cycle pulses for a good byte or a framing error.
module uart_rx_core
  import uart_avalon_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rxd,
  output logic [7:0] rx_byte,
  output logic      rx_valid,
  output logic      rx_ferr,
  output logic      rx_active,
  output rx_state_t rx_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);

  logic          rxd_meta;
  logic          rxd_sync;
  logic          rxd_prev;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  rx_state_t     state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta  <= 1'b1;
      rxd_sync  <= 1'b1;
      rxd_prev  <= 1'b1;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      rx_valid  <= 1'b0;
      rx_ferr   <= 1'b0;
      state     <= RX_IDLE;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      unique case (state)
        RX_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (rxd_prev && !rxd_sync) state <= RX_START;
        end
        RX_START: begin
          // Mid start bit: a high line here was only a glitch.
          if (clk_cnt == CNT_HALF) begin
            clk_cnt <= '0;
            state   <= rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt   <= '0;
            shift_reg <= {rxd_sync, shift_reg[7:1]};
            bit_idx   <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt  <= '0;
            rx_valid <= rxd_sync;
            rx_ferr  <= !rxd_sync;
            state    <= RX_IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign rx_byte   = shift_reg;
  assign rx_active = (state != RX_IDLE);
  assign rx_state  = state;

endmodule

// File: rtl/uart_avalon_rx.sv
// Avalon-MM receive-only UART: serial bytes land in a small FIFO which the
// host drains through a DATA register; CONTROL holds enable and error flags.
module uart_avalon_rx
  import uart_avalon_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 4
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic        uart_rxd,
  input  logic        avs_address,
  input  logic        avs_chipselect,
  input  logic [3:0]  avs_byteenable,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq,
  output logic        rx_active
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [7:0]         rx_byte;
  logic               rx_valid;
  logic               rx_ferr;
  rx_state_t          rx_state;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               re;
  logic               fe;
  logic               oe;

  logic               rd_req;
  logic               ctrl_wr;
  logic               empty;
  logic               full;
  logic               pop;
  logic               push;
  logic               push_drop;
  logic               fe_clr;
  logic               oe_clr;
  logic [31:0]        rd_word;
  logic               unused_ok;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk      (clk_50M),
    .rst_n    (reset),
    .rxd      (uart_rxd),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .rx_active(rx_active),
    .rx_state (rx_state)
  );

  assign rd_req    = avs_chipselect && avs_read;
  assign ctrl_wr   = avs_chipselect && avs_write && (avs_address == ADDR_CTRL);
  assign empty     = (count == '0);
  assign full      = (count == (FIFO_AW+1)'(DEPTH));
  assign pop       = rd_req && (avs_address == ADDR_DATA) && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign push      = rx_valid && (!full || pop);
  assign push_drop = rx_valid && full && !pop;
  assign fe_clr    = ctrl_wr && avs_byteenable[1] && avs_writedata[FE_BIT];
  assign oe_clr    = ctrl_wr && avs_byteenable[1] && avs_writedata[OE_BIT];

  always_ff @(posedge clk_50M) begin
    if (push) mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      re <= 1'b0;
      fe <= 1'b0;
      oe <= 1'b0;
    end else begin
      if (ctrl_wr && avs_byteenable[0]) re <= avs_writedata[RE_BIT];
      if (rx_ferr)     fe <= 1'b1;
      else if (fe_clr) fe <= 1'b0;
      if (push_drop)   oe <= 1'b1;
      else if (oe_clr) oe <= 1'b0;
    end
  end

  always_comb begin
    rd_word = '0;
    if (avs_address == ADDR_DATA) begin
      if (!empty) begin
        rd_word[7:0]             = mem[rd_ptr];
        rd_word[RVALID_BIT]      = 1'b1;
        rd_word[31:AVAIL_LSB]    = 16'(count) - 16'd1;
      end
    end else begin
      rd_word[RE_BIT]          = re;
      rd_word[RI_BIT]          = re && !empty;
      rd_word[FE_BIT]          = fe;
      rd_word[OE_BIT]          = oe;
      rd_word[31:AVAIL_LSB]    = 16'(DEPTH) - 16'(count);
    end
  end

  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) avs_readdata <= '0;
    else if (rd_req) avs_readdata <= rd_word;
  end

  assign irq = re && !empty;

  assign unused_ok = &{1'b0, rx_state, avs_writedata[31:11], avs_writedata[8:1],
                       avs_byteenable[3:2]};

endmodule

// File: doc/uart_avalon_rx.md
Name: uart_avalon_rx

Overview:
Avalon-MM slave responder that receives 8N1 serial bytes on RXD and buffers them in a small FIFO. A host reads the bytes through a register map compatible with the team's RS232 UART data/control layout (1-bit address, 32-bit data). It is the read-side counterpart to the write-only UART test harness and sits between the board RXD pin and any Avalon initiator (Nios, test FSM).

Parameters:
CLKS_PER_BIT, 434, clk_50M cycles per bit (50 MHz / 115200); must be >= 8.
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 bytes.

Ports:
clk_50M  in  1  system clock, single domain
reset  in  1  asynchronous, active-low reset
uart_rxd  in  1  serial input, idle high, asynchronous to clk_50M
avs_address  in  1  0 = DATA register, 1 = CONTROL register
avs_chipselect  in  1  slave select
avs_byteenable  in  4  write byte lanes
avs_read  in  1  read strobe, qualified by chipselect
avs_write  in  1  write strobe, qualified by chipselect
avs_writedata  in  32  write data
avs_readdata  out  32  registered read data
irq  out  1  RE & FIFO non-empty
rx_active  out  1  high while a frame is being received (LED)

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, count=0, RX FSM=IDLE, RE=0, FE=0, OE=0, avs_readdata=0, irq=0, rx_active=0.
- uart_rxd passes through a 2-flop synchronizer before use. It resets to 1.
- RX FSM states are IDLE, START, DATA, STOP. A bit counter runs 0..CLKS_PER_BIT-1 and a bit index runs 0..7.
  - IDLE -> START on the synchronized falling edge.
  - START: sample at CLKS_PER_BIT/2. If the sample is 1 (glitch), return to IDLE with no side effects. If 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, 8 bits, then go to STOP.
  - STOP: sample one bit period later. If 1, push the byte. If 0, discard the byte and set FE. Then return to IDLE with no extra idle wait.
  - rx_active=1 in every state except IDLE.
- Push when the FIFO is full: the byte is dropped and OE is set. Exception: if a pop occurs in the same cycle, the push is accepted.
- Read latency is 1. avs_readdata updates on the clk_50M edge after a cycle with chipselect&read, and holds its value otherwise.
- DATA read (address 0):
  - Returns [7:0] = head byte, [15] = RVALID (FIFO was non-empty), [31:16] = RAVAIL (count after this pop), all other bits 0.
  - If the FIFO was non-empty, the head is popped.
  - If empty: returns 0x00000000 and pops nothing.
- CONTROL read (address 1):
  - Returns [0] = RE, [8] = RI = RE&non-empty, [9] = FE, [10] = OE, [31:16] = free space (2**FIFO_AW - count).
  - No side effects.
- DATA write: ignored. The block has no transmitter.
- CONTROL write:
  - byteenable[0] writes RE = writedata[0].
  - byteenable[1] with writedata[9]=1 clears FE; with writedata[10]=1 clears OE (write-1-to-clear).
  - If a set and a clear of the same flag occur in the same cycle, set wins.
- Simultaneous push and pop: count is unchanged, and both the data and the pointers update correctly. Pointers wrap modulo depth. Count is FIFO_AW+1 bits wide.
- chipselect=0 means read and write are ignored.
- irq is combinational from registered state and has no glitch paths.
- Reset asserted mid-frame aborts the frame. After release, the FSM waits in IDLE for the next falling edge.

Decomposition:
- Package uart_avalon_pkg holds:
  - register offsets ADDR_DATA=0, ADDR_CTRL=1;
  - bit positions RVALID_BIT=15, RE_BIT=0, RI_BIT=8, FE_BIT=9, OE_BIT=10, AVAIL_LSB=16;
  - an RX state enum.
- Sub-module uart_rx_core contains the synchronizer, FSM and shift register. Its outputs are rx_byte[7:0], rx_valid (1-cycle pulse), rx_ferr (1-cycle pulse) and rx_active.
- The FIFO and register file stay in the top module.

Test Plan:
- Serial 0xA5 at CLKS_PER_BIT=434, then DATA read -> 0x000080A5. A second DATA read -> 0x00000000. CONTROL read before the first read, with RE=1 -> bit8=1, [31:16]=15.
- Three bytes 0x01,0x02,0x03, then three DATA reads -> 0x00028001, 0x00018002, 0x00008003. irq (RE=1) drops the cycle after the third read.
- Frame 0x3C with stop bit 0 -> FIFO stays empty and CONTROL bit9=1. Write 0x00000200 with byteenable=4'b0010 -> bit9=0.
- 17 bytes with no reads -> CONTROL [31:16]=0 and bit10=1. Sixteen DATA reads return the first 16 bytes in order, and the 17th byte is absent.
- RXD low pulse of 100 cycles -> no byte, FSM returns to IDLE. A valid 0x55 sent immediately after is received correctly.
- reset=0 asserted at data bit 4 of 0xFF, released, then 0x81 sent -> a single DATA read returns 0x00008081.
